// File: rtl/dphy_timer_bank.sv
// dphy_timer_bank
//   A bank of N_CH independent down-counting interval timers for the D-PHY
//   lane control FSMs. Each channel can run one-shot or periodic, and can be
//   started, restarted, stopped and paused. Every output is registered.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start[i]     load reload[i] and run (restarts a running channel)
//   stop[i]      abort to IDLE, count cleared, no expiry (highest priority)
//   pause[i]     freeze a running channel's counter; no expiry while held
//   periodic[i]  1 = reload on expiry and keep running, 0 = one-shot
//   reload       per-channel reload, channel i at [i*CNT_W +: CNT_W]
//   busy[i]      channel is in RUN
//   expired[i]   one-cycle pulse when the interval completes
//   expired_any  registered OR of all expiry pulses, aligned with expired
//   count        live counter values, packed the same way as reload
module dphy_timer_bank #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         start,
   input  logic [N_CH-1:0]         stop,
   input  logic [N_CH-1:0]         pause,
   input  logic [N_CH-1:0]         periodic,
   input  logic [N_CH*CNT_W-1:0]   reload,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         expired,
   output logic                    expired_any,
   output logic [N_CH*CNT_W-1:0]   count
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state expiry of every channel, OR-ed into expired_any so that the
   // combined flag lands on the same edge as the per-channel pulses.
   logic [N_CH-1:0] expired_d;
   logic            expired_any_q;
   logic            expired_any_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [0:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             exp_q, exp_d;
      logic [CNT_W-1:0] rl;

      assign rl = reload[i*CNT_W +: CNT_W];

      // stop > start > pause > count
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         exp_d   = 1'b0;
         if (stop[i]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else if (start[i]) begin
            state_d = ST_RUN;
            cnt_d   = rl;
         end else if (state_q == ST_IDLE) begin
            cnt_d   = '0;
         end else if (!pause[i]) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else begin
               // Zero is the terminal count: expire instead of wrapping.
               exp_d = 1'b1;
               if (periodic[i]) cnt_d = rl;
               else             state_d = ST_IDLE;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
         end
      end

      assign busy[i]                   = (state_q == ST_RUN);
      assign expired[i]                = exp_q;
      assign count[i*CNT_W +: CNT_W]   = cnt_q;
      assign expired_d[i]              = exp_d;
   end

   assign expired_any_d = |expired_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) expired_any_q <= 1'b0;
      else     expired_any_q <= expired_any_d;
   end

   assign expired_any = expired_any_q;

endmodule

// File: tb/tb_dphy_timer_bank.sv
module tb_dphy_timer_bank;
   localparam int N_CH  = 4;
   localparam int CNT_W = 6;
   localparam int WW    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N_CH-1:0]       start = '0, stop = '0, pause = '0, periodic = '0;
   logic [N_CH*CNT_W-1:0] reload = '0;
   logic [N_CH-1:0]       busy, expired;
   logic                  expired_any;
   logic [N_CH*CNT_W-1:0] count;

   dphy_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .periodic(periodic), .reload(reload), .busy(busy), .expired(expired),
      .expired_any(expired_any), .count(count));

   // Single-channel, 16-bit instance for the long-interval corner.
   logic          rst_w = 1'b1;
   logic [0:0]    start_w = '0, stop_w = '0, pause_w = '0, periodic_w = '0;
   logic [WW-1:0] reload_w = '0;
   logic [0:0]    busy_w, expired_w;
   logic          expired_any_w;
   logic [WW-1:0] count_w;

   dphy_timer_bank #(.N_CH(1), .CNT_W(WW)) dut_w (
      .clk(clk), .rst(rst_w), .start(start_w), .stop(stop_w), .pause(pause_w),
      .periodic(periodic_w), .reload(reload_w), .busy(busy_w),
      .expired(expired_w), .expired_any(expired_any_w), .count(count_w));

   int errs = 0, checks = 0;
   bit wide_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: rem = clock edges still to go until the expiry edge.
   // Displayed count is rem-1 while running.
   int rem [N_CH];
   bit run [N_CH];
   bit mexp[N_CH];
   bit many;

   function automatic int rl_of(int i);
      return int'(reload[i*CNT_W +: CNT_W]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N_CH; i++) begin
         rem[i] = 0; run[i] = 0; mexp[i] = 0;
      end
      many = 0;
   endtask

   task automatic model_step();
      many = 0;
      for (int i = 0; i < N_CH; i++) begin
         mexp[i] = 0;
         if (stop[i]) begin
            run[i] = 0; rem[i] = 0;
         end else if (start[i]) begin
            run[i] = 1; rem[i] = rl_of(i) + 1;
         end else if (run[i] && !pause[i]) begin
            rem[i]--;
            if (rem[i] == 0) begin
               mexp[i] = 1;
               if (periodic[i]) rem[i] = rl_of(i) + 1;
               else             run[i] = 0;
            end
         end
         many |= mexp[i];
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < N_CH; i++) begin
         chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(run[i]));
         chk($sformatf("expired%0d", i), 32'(expired[i]), 32'(mexp[i]));
         chk($sformatf("count%0d", i), 32'(count[i*CNT_W +: CNT_W]),
             32'(run[i] ? rem[i] - 1 : 0));
      end
      chk("expired_any", 32'(expired_any), 32'(many));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic set_rl(input int ch, input int v);
      reload[ch*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   function automatic int cnt(int ch);
      return int'(count[ch*CNT_W +: CNT_W]);
   endfunction

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_expired", 32'(expired), 0);
      chk("rst_any", 32'(expired_any), 0);
      chk("rst_count", 32'(count), 0);
      @(negedge clk) rst = 1'b0;

      // One-shot, reload 5
      set_rl(0, 5); start[0] = 1; tick(); start[0] = 0;
      chk("s1_cnt", cnt(0), 5);
      chk("s1_busy", 32'(busy[0]), 1);
      for (int k = 4; k >= 0; k--) begin
         tick();
         chk("s1_cnt", cnt(0), k);
         chk("s1_noexp", 32'(expired[0]), 0);
      end
      tick();
      chk("s1_exp", 32'(expired[0]), 1);
      chk("s1_idle", 32'(busy[0]), 0);
      chk("s1_cnt0", cnt(0), 0);
      tick();
      chk("s1_pulse1", 32'(expired[0]), 0);

      // Periodic, reload changed mid-interval
      set_rl(1, 3); periodic[1] = 1; start[1] = 1; tick(); start[1] = 0;
      repeat (6) tick();
      set_rl(1, 1);
      repeat (12) tick();
      periodic[1] = 0; stop[1] = 1; tick(); stop[1] = 0;
      chk("s2_stopped", 32'(busy[1]), 0);

      // Pause for 4 cycles at count 6: expiry 15 clocks after start
      set_rl(2, 10); start[2] = 1; tick(); start[2] = 0;
      repeat (4) tick();
      chk("s3_cnt6", cnt(2), 6);
      pause[2] = 1; repeat (4) tick(); pause[2] = 0;
      chk("s3_held", cnt(2), 6);
      repeat (6) tick();
      chk("s3_early", 32'(expired[2]), 0);
      tick();
      chk("s3_exp", 32'(expired[2]), 1);

      // stop+start at terminal count, then restart at count 2
      set_rl(3, 8); start[3] = 1; tick(); start[3] = 0;
      repeat (8) tick();
      chk("s4_zero", cnt(3), 0);
      stop[3] = 1; start[3] = 1; tick(); stop[3] = 0; start[3] = 0;
      chk("s4_noexp", 32'(expired[3]), 0);
      chk("s4_idle", 32'(busy[3]), 0);
      chk("s4_cnt", cnt(3), 0);
      start[3] = 1; tick(); start[3] = 0;
      repeat (6) tick();
      chk("s4_cnt2", cnt(3), 2);
      start[3] = 1; tick(); start[3] = 0;
      chk("s4_reload", cnt(3), 8);
      chk("s4_restart_noexp", 32'(expired[3]), 0);
      stop[3] = 1; tick(); stop[3] = 0;

      // Simultaneous expiry on channels 0 and 2
      set_rl(0, 4); set_rl(2, 4); start[0] = 1; start[2] = 1; tick();
      start = '0;
      repeat (4) tick();
      chk("s5_any_pre", 32'(expired_any), 0);
      tick();
      chk("s5_exp", 32'(expired & 4'b0101), 32'h5);
      chk("s5_any", 32'(expired_any), 1);
      tick();
      chk("s5_any_post", 32'(expired_any), 0);

      // Asynchronous reset between edges
      for (int i = 0; i < N_CH; i++) set_rl(i, 20);
      start = '1; tick(); start = '0;
      repeat (5) tick();
      #3 rst = 1'b1;
      #1;
      chk("ar_busy", 32'(busy), 0);
      chk("ar_count", 32'(count), 0);
      chk("ar_expired", 32'(expired), 0);
      chk("ar_any", 32'(expired_any), 0);
      model_clear();
      #2 rst = 1'b0;
      repeat (30) tick();

      // Randomized traffic
      repeat (2000) begin
         for (int i = 0; i < N_CH; i++) begin
            start[i]    = ($urandom_range(0, 11) == 0);
            stop[i]     = ($urandom_range(0, 39) == 0);
            pause[i]    = ($urandom_range(0, 4) == 0);
            periodic[i] = 1'($urandom_range(0, 1));
            set_rl(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                                   : int'($urandom_range(0, 6)));
         end
         tick();
      end

      wait (wide_done);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // 16-bit channel, reload 0xFFFF: expiry 65536 clocks after start
   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_w = 1'b0;
      reload_w = 16'hFFFF; start_w = 1'b1;
      @(posedge clk);
      #1 start_w = 1'b0;
      chk("w_cnt0", 32'(count_w), 65535);
      chk("w_busy", 32'(busy_w), 1);
      n = 0;
      while (n < 70000 && !expired_w[0]) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("w_latency", n, 65536);
      chk("w_idle", 32'(busy_w), 0);
      chk("w_cnt", 32'(count_w), 0);
      chk("w_any", 32'(expired_any_w), 1);
      wide_done = 1'b1;
   end
endmodule
